score_renderer: RTL and testbench

Holds both players' scores and turns VGA pixel coordinates into lookups in the 64x64 digit glyph ROM. It sits directly upstream of that ROM: it drives the digit-select and 12-bit glyph address, takes back the 3-bit RGB glyph pixel, and outputs a pipelined score-layer colour to the pixel mixer. It also handles point counting, win detection and frame-synchronous score latching, so digits never tear mid-frame.

---
 rtl/score_renderer_if.sv | 9 +
 rtl/score_renderer.sv | 158 +++++++++++++++
 tb/tb_score_renderer.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/score_renderer_if.sv
// Glyph ROM link: digit select and glyph address out, one RGB glyph pixel back.
interface score_renderer_if;
   logic [3:0]  rom_digit;
   logic [11:0] rom_address;
   logic [2:0]  rom_data;

   modport master (output rom_digit, output rom_address, input rom_data);
   modport slave  (input rom_digit, input rom_address, output rom_data);
endinterface

// File: rtl/score_renderer.sv
// Score keeping, win detection, frame-latched digit display and the
// two-stage pipeline that maps pixel coordinates onto the digit glyph ROM.
module score_renderer #(
   parameter int unsigned LEFT_X    = 192,
   parameter int unsigned RIGHT_X   = 384,
   parameter int unsigned TOP_Y     = 32,
   parameter int unsigned WIN_SCORE = 9
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [9:0]             pixel_x,
   input  logic [9:0]             pixel_y,
   input  logic                   video_on,
   input  logic                   frame_start,
   input  logic                   point_left,
   input  logic                   point_right,
   input  logic                   new_game,
   score_renderer_if.master       rom,
   output logic [2:0]             rgb_out,
   output logic [3:0]             score_left,
   output logic [3:0]             score_right,
   output logic                   game_over,
   output logic                   winner
);

   localparam int unsigned BOX = 64;
   localparam logic [10:0] LX_LO = 11'(LEFT_X);
   localparam logic [10:0] LX_HI = 11'(LEFT_X + BOX);
   localparam logic [10:0] RX_LO = 11'(RIGHT_X);
   localparam logic [10:0] RX_HI = 11'(RIGHT_X + BOX);
   localparam logic [10:0] TY_LO = 11'(TOP_Y);
   localparam logic [10:0] TY_HI = 11'(TOP_Y + BOX);
   localparam logic [3:0]  WIN   = 4'(WIN_SCORE);

   typedef enum logic {PLAY = 1'b0, OVER = 1'b1} state_t;

   state_t      state;
   logic [3:0]  disp_left;
   logic [3:0]  disp_right;
   logic [3:0]  left_inc;
   logic [3:0]  right_inc;
   logic        left_win;
   logic        right_win;

   logic [10:0] x_ext;
   logic [10:0] y_ext;
   logic        in_y;
   logic        in_left;
   logic        in_right;
   logic [5:0]  row;
   logic [5:0]  col_left;
   logic [5:0]  col_right;
   logic [3:0]  digit_nxt;
   logic [11:0] addr_nxt;
   logic        hit_q;
   logic        video_on_q;

   // Candidate scores for this cycle's point pulses
   assign left_inc  = score_left  + {3'b000, point_left};
   assign right_inc = score_right + {3'b000, point_right};
   assign left_win  = (left_inc == WIN);
   assign right_win = (right_inc == WIN);

   // Score FSM: PLAY counts points, OVER freezes them until new_game
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= PLAY;
         score_left  <= '0;
         score_right <= '0;
         game_over   <= 1'b0;
         winner      <= 1'b0;
      end else if (new_game) begin
         state       <= PLAY;
         score_left  <= '0;
         score_right <= '0;
         game_over   <= 1'b0;
         winner      <= 1'b0;
      end else begin
         case (state)
            PLAY: begin
               score_left  <= left_inc;
               score_right <= right_inc;
               if (left_win || right_win) begin
                  state     <= OVER;
                  game_over <= 1'b1;
                  winner    <= !left_win;
               end
            end
            OVER: begin
               state <= OVER;
            end
            default: begin
               state <= PLAY;
            end
         endcase
      end
   end

   // Displayed digits change only at frame start, using pre-update scores
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         disp_left  <= '0;
         disp_right <= '0;
      end else if (frame_start) begin
         disp_left  <= score_left;
         disp_right <= score_right;
      end
   end

   // Box hit test; 11-bit compares keep origin+64 from overflowing
   assign x_ext    = {1'b0, pixel_x};
   assign y_ext    = {1'b0, pixel_y};
   assign in_y     = (y_ext >= TY_LO) && (y_ext < TY_HI);
   assign in_left  = in_y && (x_ext >= LX_LO) && (x_ext < LX_HI);
   assign in_right = in_y && !in_left && (x_ext >= RX_LO) && (x_ext < RX_HI);

   assign row       = 6'(pixel_y - 10'(TOP_Y));
   assign col_left  = 6'(pixel_x - 10'(LEFT_X));
   assign col_right = 6'(pixel_x - 10'(RIGHT_X));

   // Outside the boxes keep the ROM on a legal digit with address 0
   always_comb begin
      digit_nxt = disp_left;
      addr_nxt  = '0;
      if (in_left) begin
         digit_nxt = disp_left;
         addr_nxt  = {row, col_left};
      end else if (in_right) begin
         digit_nxt = disp_right;
         addr_nxt  = {row, col_right};
      end
   end

   // Stage 1: ROM request plus the qualifiers that travel with it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rom.rom_digit   <= '0;
         rom.rom_address <= '0;
         hit_q           <= 1'b0;
         video_on_q      <= 1'b0;
      end else begin
         rom.rom_digit   <= digit_nxt;
         rom.rom_address <= addr_nxt;
         hit_q           <= in_left || in_right;
         video_on_q      <= video_on;
      end
   end

   // Stage 2: gate the returned glyph pixel
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rgb_out <= '0;
      end else begin
         rgb_out <= (hit_q && video_on_q) ? rom.rom_data : 3'b000;
      end
   end

endmodule

// File: tb/tb_score_renderer.sv
// Directed bench for score_renderer with a small behavioural glyph ROM.
module tb_score_renderer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [9:0] pixel_x;
   logic [9:0] pixel_y;
   logic       video_on;
   logic       frame_start;
   logic       point_left;
   logic       point_right;
   logic       new_game;
   logic [2:0] rgb_out;
   logic [3:0] score_left;
   logic [3:0] score_right;
   logic       game_over;
   logic       winner;

   int n_vec = 0;
   int n_bad = 0;

   score_renderer_if rif ();

   score_renderer dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .pixel_x     (pixel_x),
      .pixel_y     (pixel_y),
      .video_on    (video_on),
      .frame_start (frame_start),
      .point_left  (point_left),
      .point_right (point_right),
      .new_game    (new_game),
      .rom         (rif),
      .rgb_out     (rgb_out),
      .score_left  (score_left),
      .score_right (score_right),
      .game_over   (game_over),
      .winner      (winner)
   );

   always #5 clk = ~clk;

   // Glyph ROM stand-in: always non-zero, depends on digit and address
   function automatic logic [2:0] rom_fn(input logic [3:0] d, input logic [11:0] a);
      return (d[2:0] ^ a[2:0] ^ a[8:6]) | 3'b001;
   endfunction

   assign rif.rom_data = rom_fn(rif.rom_digit, rif.rom_address);

   typedef struct {
      logic [9:0]  x;
      logic [9:0]  y;
      logic        vid;
      logic [3:0]  digit;
      logic [11:0] addr;
      logic [2:0]  rgb;
   } vec_t;

   task automatic chk(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse(input logic pl, input logic pr, input logic ng, input logic fs);
      point_left  = pl;
      point_right = pr;
      new_game    = ng;
      frame_start = fs;
      step();
      point_left  = 1'b0;
      point_right = 1'b0;
      new_game    = 1'b0;
      frame_start = 1'b0;
   endtask

   task automatic set_pix(input int x, input int y, input logic vid);
      pixel_x  = 10'(x);
      pixel_y  = 10'(y);
      video_on = vid;
   endtask

   vec_t v [13];

   initial begin
      // Scores 3:2 latched; rgb from rom_fn worked by hand
      v[0]  = '{10'd192, 10'd32, 1'b1, 4'd3, 12'd0,    3'd3};
      v[1]  = '{10'd197, 10'd39, 1'b1, 4'd3, 12'd453,  3'd1};
      v[2]  = '{10'd255, 10'd95, 1'b1, 4'd3, 12'd4095, 3'd3};
      v[3]  = '{10'd256, 10'd95, 1'b1, 4'd3, 12'd0,    3'd0};
      v[4]  = '{10'd191, 10'd32, 1'b1, 4'd3, 12'd0,    3'd0};
      v[5]  = '{10'd192, 10'd31, 1'b1, 4'd3, 12'd0,    3'd0};
      v[6]  = '{10'd192, 10'd96, 1'b1, 4'd3, 12'd0,    3'd0};
      v[7]  = '{10'd197, 10'd39, 1'b0, 4'd3, 12'd453,  3'd0};
      v[8]  = '{10'd384, 10'd32, 1'b1, 4'd2, 12'd0,    3'd3};
      v[9]  = '{10'd447, 10'd95, 1'b1, 4'd2, 12'd4095, 3'd3};
      v[10] = '{10'd447, 10'd32, 1'b1, 4'd2, 12'd63,   3'd5};
      v[11] = '{10'd400, 10'd40, 1'b1, 4'd2, 12'd528,  3'd3};
      v[12] = '{10'd448, 10'd32, 1'b1, 4'd3, 12'd0,    3'd0};

      rst_n = 1'b0;
      set_pix(0, 0, 1'b0);
      point_left = 1'b0; point_right = 1'b0; new_game = 1'b0; frame_start = 1'b0;
      step();
      step();
      chk("reset rgb_out", int'(rgb_out), 0);
      chk("reset score_left", int'(score_left), 0);
      chk("reset score_right", int'(score_right), 0);
      chk("reset game_over", int'(game_over), 0);
      chk("reset winner", int'(winner), 0);
      chk("reset rom_digit", int'(rif.rom_digit), 0);
      chk("reset rom_address", int'(rif.rom_address), 0);
      rst_n = 1'b1;
      step();

      // Digit 0 at the left box origin, two-cycle latency
      pulse(1'b0, 1'b0, 1'b0, 1'b1);
      set_pix(192, 32, 1'b1);
      step();
      chk("d0 rom_digit", int'(rif.rom_digit), 0);
      chk("d0 rom_address", int'(rif.rom_address), 0);
      chk("d0 rgb early", int'(rgb_out), 0);
      set_pix(0, 0, 1'b0);
      step();
      chk("d0 rgb_out", int'(rgb_out), int'(rom_fn(4'd0, 12'd0)));

      // Scores change but display holds until frame_start
      repeat (3) pulse(1'b1, 1'b0, 1'b0, 1'b0);
      repeat (2) pulse(1'b0, 1'b1, 1'b0, 1'b0);
      chk("score_left 3", int'(score_left), 3);
      chk("score_right 2", int'(score_right), 2);
      set_pix(197, 39, 1'b1);
      step();
      chk("pre-frame digit", int'(rif.rom_digit), 0);
      pulse(1'b0, 1'b0, 1'b0, 1'b1);

      // Back-to-back pixel table
      for (int i = 0; i < 13; i++) begin
         set_pix(int'(v[i].x), int'(v[i].y), v[i].vid);
         step();
         chk($sformatf("vec%0d rom_digit", i), int'(rif.rom_digit), int'(v[i].digit));
         chk($sformatf("vec%0d rom_address", i), int'(rif.rom_address), int'(v[i].addr));
         if (i > 0) chk($sformatf("vec%0d rgb_out", i - 1), int'(rgb_out), int'(v[i - 1].rgb));
      end
      step();
      chk("vec12 rgb_out", int'(rgb_out), int'(v[12].rgb));

      // Point without frame_start, then frame_start coinciding with a point
      set_pix(197, 39, 1'b1);
      pulse(1'b1, 1'b0, 1'b0, 1'b0);
      chk("score_left 4", int'(score_left), 4);
      chk("stale digit 3", int'(rif.rom_digit), 3);
      pulse(1'b1, 1'b0, 1'b0, 1'b1);
      chk("score_left 5", int'(score_left), 5);
      step();
      chk("pre-increment latch", int'(rif.rom_digit), 4);
      pulse(1'b0, 1'b0, 1'b0, 1'b1);
      step();
      chk("latched digit 5", int'(rif.rom_digit), 5);

      // Drive both to 8, then a simultaneous win
      repeat (3) pulse(1'b1, 1'b0, 1'b0, 1'b0);
      repeat (6) pulse(1'b0, 1'b1, 1'b0, 1'b0);
      chk("8:8 left", int'(score_left), 8);
      chk("8:8 right", int'(score_right), 8);
      chk("8:8 game_over", int'(game_over), 0);
      pulse(1'b1, 1'b1, 1'b0, 1'b0);
      chk("tie left", int'(score_left), 9);
      chk("tie right", int'(score_right), 9);
      chk("tie game_over", int'(game_over), 1);
      chk("tie winner", int'(winner), 0);
      pulse(1'b1, 1'b1, 1'b0, 1'b0);
      chk("over hold left", int'(score_left), 9);
      chk("over hold right", int'(score_right), 9);

      // Right-only win
      pulse(1'b0, 1'b0, 1'b1, 1'b0);
      chk("new_game left", int'(score_left), 0);
      chk("new_game game_over", int'(game_over), 0);
      repeat (9) pulse(1'b0, 1'b1, 1'b0, 1'b0);
      chk("right win score", int'(score_right), 9);
      chk("right win game_over", int'(game_over), 1);
      chk("right win winner", int'(winner), 1);
      pulse(1'b1, 1'b0, 1'b0, 1'b0);
      chk("over ignores left", int'(score_left), 0);

      // new_game beats a point pulse in the same cycle
      pulse(1'b0, 1'b1, 1'b1, 1'b0);
      chk("ng+pt left", int'(score_left), 0);
      chk("ng+pt right", int'(score_right), 0);
      chk("ng+pt game_over", int'(game_over), 0);
      chk("ng+pt winner", int'(winner), 0);

      // Mid-operation reset flushes the pipeline
      pulse(1'b0, 1'b0, 1'b0, 1'b1);
      set_pix(192, 32, 1'b1);
      step();
      step();
      chk("pre-reset rgb", int'(rgb_out), int'(rom_fn(4'd0, 12'd0)));
      #2 rst_n = 1'b0;
      #1;
      chk("async reset rgb", int'(rgb_out), 0);
      step();
      rst_n = 1'b1;
      step();
      chk("post-reset stage1 rgb", int'(rgb_out), 0);
      chk("post-reset rom_address", int'(rif.rom_address), 0);
      step();
      chk("post-reset rgb", int'(rgb_out), int'(rom_fn(4'd0, 12'd0)));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
